// File: rtl/count_bus_pkg.sv
// Shared types and constants for the counter's uio bus preload protocol.
// Used by both the preload driver and anything modelling the counter side.
package count_bus_pkg;

    localparam int         BUS_W       = 8;
    localparam logic [1:0] SEQ_RELEASE = 2'd1;
    localparam logic [1:0] SEQ_CAPTURE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT,
        DRIVE,
        READBACK,
        GAP
    } state_t;

    // One down-counter covers both the WAIT and GAP phases, so size it for the longer.
    function automatic int delay_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/preload_delay_cnt.sv
// Loadable down-counter with a zero flag; it stops at zero until reloaded.
module preload_delay_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/count_preload_driver.sv
// Peer-side driver that preloads the 8-bit counter over the shared uio bus.
// Optional readback of the loaded value is enabled by defining READBACK_CHECK_EN.
module count_preload_driver
    import count_bus_pkg::*;
#(
    parameter int LOAD_TO_CAP = 3,
    parameter int IDLE_GAP    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [BUS_W-1:0] req_data,
    output logic             load_o,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_out,
    output logic [BUS_W-1:0] bus_oe,
    output logic             resp_valid,
    output logic             resp_ok,
    output logic [BUS_W-1:0] resp_data,
    output logic             busy
);

    localparam int               CNT_W     = delay_cnt_w(LOAD_TO_CAP, IDLE_GAP);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LOAD_TO_CAP - 2);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(IDLE_GAP - 1);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               resp_fire;
    logic               rb_ok;
    logic [BUS_W-1:0]   rb_data;

    logic               ready_q;
    logic               load_q;
    logic               oe_q;
    logic               resp_valid_q;
    logic               resp_ok_q;
    logic [BUS_W-1:0]   resp_data_q;
    logic [BUS_W-1:0]   bus_out_q;

    assign accept = req_valid && ready_q && (state_q == IDLE);

    preload_delay_cnt #(
        .W(CNT_W)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(cnt_val),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_val   = WAIT_LOAD;
        resp_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = PULSE;
            end
            PULSE: begin
                state_d  = WAIT;
                cnt_load = 1'b1;
                cnt_val  = WAIT_LOAD;
            end
            WAIT: begin
                if (cnt_zero) state_d = DRIVE;
            end
            DRIVE: begin
`ifdef READBACK_CHECK_EN
                state_d   = READBACK;
`else
                state_d   = GAP;
                cnt_load  = 1'b1;
                cnt_val   = GAP_LOAD;
                resp_fire = 1'b1;
`endif
            end
`ifdef READBACK_CHECK_EN
            READBACK: begin
                state_d   = GAP;
                cnt_load  = 1'b1;
                cnt_val   = GAP_LOAD;
                resp_fire = 1'b1;
            end
`endif
            GAP: begin
                if (cnt_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef READBACK_CHECK_EN
    // A floating bus (counter output disabled) is reported as a mismatch, never masked.
    assign rb_data = bus_in;
    assign rb_ok   = (bus_in == bus_out_q);
`else
    logic bus_in_unused;
    assign bus_in_unused = ^bus_in;
    assign rb_data       = bus_out_q;
    assign rb_ok         = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            load_q       <= 1'b0;
            oe_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_data_q  <= '0;
            bus_out_q    <= '0;
        end else begin
            // Ready is registered so it stays low through reset and rises one cycle into IDLE.
            ready_q      <= (state_q == IDLE) && !accept;
            load_q       <= accept;
            oe_q         <= (state_d == DRIVE);
            resp_valid_q <= resp_fire;
            if (accept) begin
                bus_out_q <= req_data;
            end
            if (resp_fire) begin
                resp_ok_q   <= rb_ok;
                resp_data_q <= rb_data;
            end
        end
    end

    assign req_ready  = ready_q;
    assign load_o     = load_q;
    assign bus_out    = bus_out_q;
    assign bus_oe     = {BUS_W{oe_q}};
    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_count_preload_driver.sv
// Bench pairing count_preload_driver with a behavioural model of the 8-bit counter
// on a shared bus; responses are checked by a queue-based scoreboard.
module tb_count_preload_driver;
    import count_bus_pkg::*;

    localparam int L = 3;
    localparam int G = 1;
`ifdef READBACK_CHECK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef struct packed {
        logic       ok;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       load_o;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic [7:0] bus_oe;
    logic       resp_valid;
    logic       resp_ok;
    logic [7:0] resp_data;
    logic       busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   load_cnt = 0;
    int   last_load_cyc = 0;
    int   prev_load_cyc = 0;
    int   resp_pulses = 0;
    bit   prev_load = 0;
    bit   prev_oe = 0;
    bit   force0 = 0;
    exp_t sb_q[$];

    // Counter model: edge-detects load, then RELEASE, CAPTURE, and drives again.
    logic [7:0] cnt;
    logic [1:0] seq;
    logic       ld_s;
    logic       ld_d;
    logic       cnt_oe;
    logic [7:0] bus_wire;

    assign cnt_oe   = (seq == 2'd0);
    assign bus_wire = (bus_oe & bus_out) | ({8{cnt_oe}} & cnt);
    assign bus_in   = force0 ? 8'h00 : bus_wire;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 8'h00;
            seq  <= 2'd0;
            ld_s <= 1'b0;
            ld_d <= 1'b0;
        end else begin
            ld_s <= load_o;
            ld_d <= ld_s;
            if (seq == SEQ_CAPTURE) begin
                cnt <= bus_wire;
                seq <= 2'd0;
            end else if (seq == SEQ_RELEASE) begin
                seq <= SEQ_CAPTURE;
            end else begin
                cnt <= cnt + 8'd1;
                if (ld_s && !ld_d) seq <= SEQ_RELEASE;
            end
        end
    end

    count_preload_driver #(
        .LOAD_TO_CAP(L),
        .IDLE_GAP   (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .load_o    (load_o),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .resp_valid(resp_valid),
        .resp_ok   (resp_ok),
        .resp_data (resp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every response, plus load/drive protocol checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (resp_valid) begin
                resp_pulses++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected: got ok=%0b data=0x%02h, required no response",
                             resp_ok, resp_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_ok", int'(resp_ok), int'(e.ok));
                    chk("resp_data", int'(resp_data), int'(e.data));
                end
            end
            if (load_o) begin
                chk("load_single_cycle", int'(prev_load), 0);
                if (!prev_load) begin
                    load_cnt++;
                    prev_load_cyc = last_load_cyc;
                    last_load_cyc = cyc;
                end
            end
            if (bus_oe != 8'h00) begin
                chk("oe_all_bits", int'(bus_oe), 'hFF);
                chk("oe_cycles_after_load", cyc - last_load_cyc, L);
                chk("oe_single_cycle", int'(prev_oe), 0);
                chk("bus_contention", int'(cnt_oe), 0);
            end
            prev_load = load_o;
            prev_oe   = (bus_oe != 8'h00);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got req_ready=%0b, required 1", req_ready);
        end
    endtask

    task automatic wait_load();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load_o && n < 10);
        if (!load_o) begin
            checks++;
            failures++;
            $display("FAIL load_timeout: got load_o=%0b, required 1", load_o);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic run_op(input logic [7:0] d, input bit ign, input bit hold,
                          input logic [7:0] nxt, input bit frc);
        exp_t       e;
        logic [7:0] dp1;
        dp1 = d + 8'd1;
        wait_ready();
        req_valid = 1'b1;
        req_data  = d;
`ifdef READBACK_CHECK_EN
        e.ok   = !frc;
        e.data = frc ? 8'h00 : d;
`else
        e.ok   = 1'b1;
        e.data = d;
`endif
        sb_q.push_back(e);
        wait_load();
        if (hold) begin
            req_data = nxt;
        end else begin
            req_valid = 1'b0;
            req_data  = 8'hEE;
        end
        for (int k = 1; k <= L + 1; k++) begin
            @(posedge clk);
            #1;
            if (ign && k == 1) begin
                req_valid = 1'b1;
                req_data  = 8'h3C;
            end
            if (ign && k == 2) begin
                req_valid = 1'b0;
                req_data  = 8'hEE;
            end
        end
        force0 = frc;
        @(negedge clk);
        chk("cnt_loaded", int'(cnt), int'(d));
        @(posedge clk);
        #1;
        force0 = 1'b0;
        @(negedge clk);
        chk("cnt_increment", int'(cnt), int'(dp1));
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int lc;
        int rp;
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = 8'h00;

        repeat (5) @(negedge clk);
        chk("rst_load_o", int'(load_o), 0);
        chk("rst_bus_oe", int'(bus_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_at_release", int'(req_ready), 0);
        @(negedge clk);
        chk("ready_after_release", int'(req_ready), 1);

        run_op(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);

        run_op(8'h10, 1'b0, 1'b1, 8'hF0, 1'b0);
        run_op(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("b2b_accept_spacing", last_load_cyc - prev_load_cyc, L + 3 + RB + G);

        run_op(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);

        lc = load_cnt;
        run_op(8'hC3, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("busy_ignore_loads", load_cnt - lc, 1);

        wait_ready();
        req_valid = 1'b1;
        req_data  = 8'h77;
        wait_load();
        req_valid = 1'b0;
        repeat (L) @(posedge clk);
        #2;
        chk("oe_in_drive", int'(bus_oe), 'hFF);
        rp    = resp_pulses;
        rst_n = 1'b0;
        #1;
        chk("oe_async_drop", int'(bus_oe), 0);
        chk("busy_async_drop", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_resp_after_reset", resp_pulses, rp);

        run_op(8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
        run_op(8'h99, 1'b0, 1'b0, 8'h00, 1'b1);

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("total_load_pulses", load_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
